// File: rtl/pattern_seq_ctrl_pkg.sv
// rtl/pattern_seq_ctrl_pkg.sv - shared codes, state constants and helpers for the memory-game sequencer
package pattern_seq_ctrl_pkg;

  localparam int CODE_W = 2;
  typedef logic [CODE_W-1:0] code_t;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_FETCH_S  = 4'd1;
  localparam state_t ST_SHOW     = 4'd2;
  localparam state_t ST_GAP      = 4'd3;
  localparam state_t ST_FETCH_I  = 4'd4;
  localparam state_t ST_WAIT_IN  = 4'd5;
  localparam state_t ST_LEVEL_UP = 4'd6;
  localparam state_t ST_LOSE     = 4'd7;
  localparam state_t ST_WIN      = 4'd8;

  function automatic logic is_active(input state_t s);
    return !(s == ST_IDLE || s == ST_LOSE || s == ST_WIN);
  endfunction

endpackage

// File: rtl/pattern_seq_ctrl_phase_timer.sv
// rtl/pattern_seq_ctrl_phase_timer.sv - loadable down-counter; done is high in the last cycle of a loaded phase
module phase_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // A load of N yields N cycles, the last of which flags done.
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - memory-game sequencer: pattern playback, player input check, level tracking
module pattern_seq_ctrl
  import pattern_seq_ctrl_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter int MAX_LEN    = 16,
  parameter int SHOW_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] mem_addr,
  input  code_t            mem_data,
  input  logic             btn_valid,
  input  code_t            btn_code,
  output logic             led_on,
  output code_t            led_code,
  output logic [IDX_W-1:0] level,
  output logic             playing,
  output logic             game_over,
  output logic             game_won
);

  localparam int TICK_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_LEVEL = IDX_W'(MAX_LEN);

  state_t           state;
  code_t            expected;
  logic             last_entry;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;

  assign last_entry = ((mem_addr + IDX_W'(1)) == level);

  // SHOW is armed while fetching; GAP is armed in the final SHOW cycle.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = CNT_W'(SHOW_TICKS);
    if (state == ST_FETCH_S) begin
      timer_load = 1'b1;
    end else if (state == ST_SHOW && timer_done) begin
      timer_load  = 1'b1;
      timer_value = CNT_W'(GAP_TICKS);
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      level    <= '0;
      led_code <= '0;
      expected <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_LOSE, ST_WIN: begin
          if (start) begin
            level    <= IDX_W'(1);
            mem_addr <= '0;
            state    <= ST_FETCH_S;
          end
        end
        ST_FETCH_S: begin
          led_code <= mem_data;
          state    <= ST_SHOW;
        end
        ST_SHOW: begin
          if (timer_done) state <= ST_GAP;
        end
        ST_GAP: begin
          if (timer_done) begin
            if (last_entry) begin
              mem_addr <= '0;
              state    <= ST_FETCH_I;
            end else begin
              mem_addr <= mem_addr + IDX_W'(1);
              state    <= ST_FETCH_S;
            end
          end
        end
        ST_FETCH_I: begin
          expected <= mem_data;
          state    <= ST_WAIT_IN;
        end
        ST_WAIT_IN: begin
          if (btn_valid) begin
            if (btn_code != expected) begin
              state <= ST_LOSE;
            end else if (last_entry) begin
              state <= ST_LEVEL_UP;
            end else begin
              mem_addr <= mem_addr + IDX_W'(1);
              state    <= ST_FETCH_I;
            end
          end
        end
        ST_LEVEL_UP: begin
          if (level == LAST_LEVEL) begin
            state <= ST_WIN;
          end else begin
            level    <= level + IDX_W'(1);
            mem_addr <= '0;
            state    <= ST_FETCH_S;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign led_on    = (state == ST_SHOW);
  assign playing   = is_active(state);
  assign game_over = (state == ST_LOSE);
  assign game_won  = (state == ST_WIN);

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
- Sequencer for the memory game.
- Owns the pattern index j and the current level.
- Steps j through the external pattern memory to play back the first `level` entries on the LEDs, then walks j again while checking each player button press against the stored entry.
- Advances the level on a full correct round. Ends the game on a mismatch or on completing MAX_LEN.
- Sits between the pattern ROM/RAM, the button debouncer and the LED/display driver.

Parameters:
- IDX_W, 8, width of index j and of level.
- MAX_LEN, 16, final level; must satisfy 1 <= MAX_LEN <= 2^IDX_W - 1.
- SHOW_TICKS, 25_000_000, cycles each LED stays lit during playback (>= 1).
- GAP_TICKS, 12_500_000, dark cycles between playback entries (>= 1).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle pulse to begin or restart a game.
- mem_addr, output, IDX_W, pattern memory address (= j); registered.
- mem_data, input, 2, pattern entry; valid one cycle after mem_addr changes.
- btn_valid, input, 1, single-cycle pulse: a button was pressed.
- btn_code, input, 2, which button; qualified by btn_valid.
- led_on, output, 1, playback LED enable.
- led_code, output, 2, which LED to light while led_on = 1.
- level, output, IDX_W, current level (round length).
- playing, output, 1, high in every state except IDLE/LOSE/WIN.
- game_over, output, 1, high in LOSE.
- game_won, output, 1, high in WIN.

Behaviour:
- Reset: on rst = 1 at any posedge, regardless of state or mid-phase, the block enters IDLE and clears the tick counter.
  - Reset values: mem_addr = 0, level = 0, led_on = 0, led_code = 0, playing = 0, game_over = 0, game_won = 0.
- States: IDLE, FETCH_S, SHOW, GAP, FETCH_I, WAIT_IN, LEVEL_UP, LOSE, WIN.
- IDLE:
  - start -> level = 1, j = 0, go to FETCH_S.
- FETCH_S: one cycle for memory latency; then latch led_code = mem_data, go to SHOW.
- SHOW:
  - led_on = 1 for exactly SHOW_TICKS cycles, then go to GAP.
- GAP:
  - led_on = 0 for exactly GAP_TICKS cycles.
  - If j + 1 == level: j = 0, go to FETCH_I.
  - Otherwise: j = j + 1, go to FETCH_S.
- FETCH_I: one cycle; then latch expected = mem_data, go to WAIT_IN.
- WAIT_IN: waits indefinitely for btn_valid.
  - btn_code == expected and j + 1 == level -> LEVEL_UP.
  - btn_code == expected otherwise -> j = j + 1, go to FETCH_I.
  - btn_code != expected -> LOSE.
- LEVEL_UP: one cycle.
  - If level == MAX_LEN -> WIN.
  - Otherwise: level = level + 1, j = 0, go to FETCH_S.
- LOSE / WIN:
  - level and mem_addr hold; flags stay asserted.
  - start -> same action as in IDLE (new game, level = 1).
- Ignored inputs:
  - btn_valid outside WAIT_IN is ignored; presses during playback are discarded, not queued.
  - start is ignored while playing = 1.
- Arithmetic: j + 1 and level + 1 are computed at IDX_W bits. The MAX_LEN bound guarantees no wrap.
- Timing: start to first led_on is 2 cycles (IDLE -> FETCH_S -> SHOW).
- Simultaneous events: rst has priority over start and btn_valid.

Decomposition:
- Shared package: state enum, LED/button code width constant (2), code type.
- One sub-module, phase_timer: a loadable down-counter with a done pulse, used for SHOW_TICKS and GAP_TICKS.

Test Plan (SHOW_TICKS = 3, GAP_TICKS = 2, MAX_LEN = 3, memory = {2, 0, 3, 1}):
- Playback timing: start pulse at cycle 0.
  - led_on = 1, led_code = 2 in cycles 2–4; led_on = 0 in cycles 5–6.
  - WAIT_IN by cycle 8; mem_addr = 0, level = 1.
- Level 2 playback: press btn_code = 2 in WAIT_IN.
  - level = 2.
  - Playback lights 2 then 0: 3 cycles lit each, 2 dark between them.
- Mismatch: at level 2, press 2 then 3.
  - game_over = 1, playing = 0, level stays 2.
  - A later start restarts with level = 1.
- Full win: correctly enter 2; 2,0; 2,0,3.
  - game_won = 1 after LEVEL_UP; level = 3.
  - Further btn_valid has no effect.
- Discarded presses: btn_valid = 1 with btn_code = 1 during SHOW.
  - No state change; the correct press 2 afterwards still advances.
- Reset mid-operation: rst = 1 during SHOW.
  - Next cycle: all outputs at reset values, state IDLE.
  - start ignored while rst = 1.
